// File: rtl/cla_addsub_pipe.sv
// ---------------------------------------------------------------------------
// cla_addsub_pipe
//   Pipelined carry-lookahead adder/subtractor. A WIDTH-bit a + b_eff + cin
//   is split into STAGES chunks of CW = WIDTH/STAGES bits. One chunk is added
//   per cycle, and the chunk carry is registered between stages. Each chunk is
//   built from 4-bit lookahead groups. The upper operand chunks are skewed
//   through registers, and the finished lower sum chunks travel alongside them.
//   As a result, the full sum and its flags leave the last stage together.
//   Latency is STAGES cycles and throughput is one beat per cycle.
//
// Ports
//   clk        clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand beat valid
//   in_ready   beat accepted this cycle (== advance)
//   a, b       operands, WIDTH bits
//   op_sub     0: a+b+cin, 1: a+~b+cin
//   cin        carry in (drive 1 for a plain subtract)
//   flush      synchronous kill of every in-flight beat
//   out_valid  result valid
//   out_ready  consumer accepts result
//   sum        result modulo 2^WIDTH
//   cout       carry out of the MSB (subtract: 1 = no borrow)
//   ovf        signed overflow
//   zero       sum == 0
//   neg        sum[WIDTH-1]
//
// WIDTH must be a multiple of 4*STAGES, and STAGES must be in 1..8.
// ---------------------------------------------------------------------------
module cla_addsub_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op_sub,
    input  logic             cin,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);

    localparam int CW = WIDTH / STAGES;   // chunk width
    localparam int NG = CW / 4;           // lookahead groups per chunk

    // One chunk of lookahead addition. The function returns {carry_out, sum}.
    // Carries inside each 4-bit group are flattened lookahead terms. Between
    // groups, the carry moves by group generate/propagate.
    function automatic logic [CW:0] f_cla_chunk(
        input logic [CW-1:0] fa,
        input logic [CW-1:0] fb,
        input logic          fc
    );
        logic [CW-1:0] g;
        logic [CW-1:0] p;
        logic [CW-1:0] c;
        logic [3:0]    gg;
        logic [3:0]    pp;
        logic          cg;
        logic          c1;
        logic          c2;
        logic          c3;
        logic          grp_g;
        logic          grp_p;
        g  = fa & fb;
        p  = fa | fb;
        c  = '0;
        cg = fc;
        for (int j = 0; j < NG; j++) begin
            gg = g[4*j +: 4];
            pp = p[4*j +: 4];
            c1 = gg[0] | (pp[0] & cg);
            c2 = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & cg);
            c3 = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
               | (pp[2] & pp[1] & pp[0] & cg);
            grp_g = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                  | (pp[3] & pp[2] & pp[1] & gg[0]);
            grp_p = &pp;
            c[4*j +: 4] = {c3, c2, c1, cg};
            cg = grp_g | (grp_p & cg);
        end
        return {cg, fa ^ fb ^ c};
    endfunction

    logic              w_advance;
    logic              w_accept;
    logic [STAGES-1:0] w_carry;        // combinational chunk carry-out per stage
    logic [WIDTH-1:0]  w_sum_last;     // fully assembled sum entering the output register
    logic              w_cmsb_last;    // carry into the MSB
    logic [STAGES-1:0] r_valid;
    logic [STAGES-1:0] r_carry;
    logic              r_ovf;
    logic              r_zero;
    logic              r_neg;

    // The whole pipe moves only when the output slot is empty or being drained.
    assign w_advance = !r_valid[STAGES-1] || out_ready;
    assign in_ready  = w_advance;
    // A beat presented during flush is dropped.
    assign w_accept  = in_valid && w_advance && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (flush) begin
            r_valid <= '0;
        end else if (w_advance) begin
            r_valid[0] <= w_accept;
            for (int k = 1; k < STAGES; k++) begin
                r_valid[k] <= r_valid[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_carry <= '0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
            r_neg   <= 1'b0;
        end else if (w_advance) begin
            r_carry <= w_carry;
            r_ovf   <= w_cmsb_last ^ w_carry[STAGES-1];
            r_zero  <= ~|w_sum_last;
            r_neg   <= w_sum_last[WIDTH-1];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            localparam int LO  = gi * CW;      // LSB of this stage's chunk
            localparam int REM = WIDTH - LO;   // operand bits not yet summed

            logic [REM-1:0]   w_a_rem;
            logic [REM-1:0]   w_b_rem;
            logic             w_ci;
            logic [CW:0]      w_res;
            logic [LO+CW-1:0] w_s_next;
            logic [LO+CW-1:0] r_s;             // sum bits completed so far

            if (gi == 0) begin : g_src
                assign w_a_rem  = a;
                assign w_b_rem  = op_sub ? ~b : b;
                assign w_ci     = cin;
                assign w_s_next = w_res[CW-1:0];
            end else begin : g_src
                assign w_a_rem  = g_stage[gi-1].g_skew.r_a_rem;
                assign w_b_rem  = g_stage[gi-1].g_skew.r_b_rem;
                assign w_ci     = r_carry[gi-1];
                assign w_s_next = {w_res[CW-1:0], g_stage[gi-1].r_s};
            end

            assign w_res       = f_cla_chunk(w_a_rem[CW-1:0], w_b_rem[CW-1:0], w_ci);
            assign w_carry[gi] = w_res[CW];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_s <= '0;
                end else if (w_advance) begin
                    r_s <= w_s_next;
                end
            end

            if (gi < STAGES - 1) begin : g_skew
                // Operand bits above this chunk wait here for the next stage.
                logic [REM-CW-1:0] r_a_rem;
                logic [REM-CW-1:0] r_b_rem;
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_a_rem <= '0;
                        r_b_rem <= '0;
                    end else if (w_advance) begin
                        r_a_rem <= w_a_rem[REM-1:CW];
                        r_b_rem <= w_b_rem[REM-1:CW];
                    end
                end
            end else begin : g_last
                assign w_sum_last  = w_s_next;
                // Because s = a ^ b ^ c, the carry into the MSB is recovered
                // from the MSB sum bit.
                assign w_cmsb_last = w_res[CW-1] ^ w_a_rem[CW-1] ^ w_b_rem[CW-1];
                assign sum         = r_s;
            end
        end
    endgenerate

    assign out_valid = r_valid[STAGES-1];
    assign cout      = r_carry[STAGES-1];
    assign ovf       = r_ovf;
    assign zero      = r_zero;
    assign neg       = r_neg;

endmodule
